// File: rtl/boot_strap_pkg.sv
// ---------------------------------------------------------------------------
// boot_strap_pkg
// Types shared by the boot strap sampler and its synchroniser:
//   bootmode_e    - boot source encoding presented to the boot ROM
//   strap_t       - one complete strap set {mode, dbg, clk_byp}
//   strap_state_e - capture FSM states
//   fallback_straps() - strap set used when the pads never settle
// ---------------------------------------------------------------------------
package boot_strap_pkg;

   typedef enum logic [1:0] {
      BOOT_JTAG       = 2'd0,
      BOOT_SPI_FLASH  = 2'd1,
      BOOT_HYPERFLASH = 2'd2,
      BOOT_PRELOAD    = 2'd3
   } bootmode_e;

   typedef struct packed {
      bootmode_e mode;
      logic      dbg;
      logic      clk_byp;
   } strap_t;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_FILTER,
      ST_LOCKED
   } strap_state_e;

   // Safe strap set: debug and clock bypass disabled, given boot mode.
   function automatic strap_t fallback_straps(input bootmode_e mode);
      strap_t s;
      s.mode    = mode;
      s.dbg     = 1'b0;
      s.clk_byp = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/boot_strap_sampler_sync.sv
// ---------------------------------------------------------------------------
// strap_sync
// Multi-flop synchroniser for asynchronous strap pad levels.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset, clears every stage to 0
//   d_i    - asynchronous pad levels (WIDTH bits)
//   q_o    - synchronised levels, STAGES cycles later
// ---------------------------------------------------------------------------
module strap_sync #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   // Shift chain: stage 0 samples the pads, last stage is the clean copy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/boot_strap_sampler.sv
// ---------------------------------------------------------------------------
// boot_strap_sampler
// Captures the boot strap pads once after reset (or on relatch request):
// synchronise, require a run of identical samples, then latch and flag valid.
// Falls back to safe defaults if the pads never settle within the timeout.
//   clk_i          - system clock
//   rst_i          - synchronous reset, active-high
//   boot_mode_i    - boot mode pads (async)
//   debug_en_i     - debug enable pad (async)
//   clk_byp_en_i   - clock bypass pad (async)
//   debug_lock_i   - fuse lock, forces debug_en_o low (combinational)
//   relatch_i      - pulse: re-sample the pads while locked
//   boot_mode_o    - latched boot mode
//   debug_en_o     - latched debug enable masked by debug_lock_i
//   clk_byp_en_o   - latched clock bypass enable
//   straps_valid_o - outputs hold an accepted or fallback strap set
//   straps_err_o   - last capture timed out, outputs are fallback values
// ---------------------------------------------------------------------------
module boot_strap_sampler
   import boot_strap_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned STABLE_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES    = 1024,
   parameter bootmode_e   DEFAULT_BOOT_MODE = BOOT_SPI_FLASH
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] boot_mode_i,
   input  logic       debug_en_i,
   input  logic       clk_byp_en_i,
   input  logic       debug_lock_i,
   input  logic       relatch_i,
   output logic [1:0] boot_mode_o,
   output logic       debug_en_o,
   output logic       clk_byp_en_o,
   output logic       straps_valid_o,
   output logic       straps_err_o
);

   localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned STRAP_W = $bits(strap_t);

   strap_t           pads;
   strap_t           samp;
   strap_t           prev_q;
   strap_t           latch_q;
   strap_state_e     state_q;
   logic [CNT_W-1:0] tmo_cnt_q;
   logic [CNT_W-1:0] stable_cnt_q;
   logic [CNT_W-1:0] stable_cnt_d;
   logic             valid_q;
   logic             err_q;
   logic             same;
   logic             accept;
   logic             timeout;

   assign pads.mode    = bootmode_e'(boot_mode_i);
   assign pads.dbg     = debug_en_i;
   assign pads.clk_byp = clk_byp_en_i;

   strap_sync #(
      .WIDTH  (STRAP_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (pads),
      .q_o   (samp)
   );

   // Run-length filter. The first FILTER sample has no valid predecessor
   // (prev_q still holds flush data), so it always starts a fresh run.
   always_comb begin
      same         = (tmo_cnt_q != '0) && (samp == prev_q);
      stable_cnt_d = '0;
      if (same) begin
         if (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            stable_cnt_d = stable_cnt_q;
         end else begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
         end
      end
      accept  = (stable_cnt_d == CNT_W'(STABLE_CYCLES - 1));
      timeout = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Capture FSM; tmo_cnt doubles as the flush counter while in SYNC.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_SYNC;
         tmo_cnt_q    <= '0;
         stable_cnt_q <= '0;
         prev_q       <= '0;
         latch_q      <= fallback_straps(DEFAULT_BOOT_MODE);
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         prev_q <= samp;
         case (state_q)
            ST_SYNC: begin
               if (tmo_cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
                  state_q      <= ST_FILTER;
                  tmo_cnt_q    <= '0;
                  stable_cnt_q <= '0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
            end
            ST_FILTER: begin
               stable_cnt_q <= stable_cnt_d;
               tmo_cnt_q    <= tmo_cnt_q + CNT_W'(1);
               // A stable run wins over a simultaneous timeout.
               if (accept) begin
                  latch_q <= samp;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= ST_LOCKED;
               end else if (timeout) begin
                  latch_q <= fallback_straps(DEFAULT_BOOT_MODE);
                  err_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               // Old strap set stays visible until the next capture latches.
               if (relatch_i) begin
                  valid_q      <= 1'b0;
                  state_q      <= ST_SYNC;
                  tmo_cnt_q    <= '0;
                  stable_cnt_q <= '0;
               end
            end
            default: begin
               state_q <= ST_SYNC;
            end
         endcase
      end
   end

   assign boot_mode_o    = latch_q.mode;
   assign debug_en_o     = latch_q.dbg & ~debug_lock_i;
   assign clk_byp_en_o   = latch_q.clk_byp;
   assign straps_valid_o = valid_q;
   assign straps_err_o   = err_q;

endmodule

// File: tb/tb_boot_strap_sampler.sv
// ---------------------------------------------------------------------------
// tb_boot_strap_sampler
// Table-driven static captures, hand-written corner sequences (timeout,
// glitch, relatch, debug lock, mid-capture reset) and randomized pad
// sequences checked against a run-length reference model.
// Observed vector layout: {valid, err, mode[1:0], debug_en, clk_byp}.
// ---------------------------------------------------------------------------
module tb_boot_strap_sampler;

   localparam int unsigned SYNC_STAGES    = 2;
   localparam int unsigned STABLE_CYCLES  = 16;
   localparam int unsigned TIMEOUT_CYCLES = 1024;
   localparam logic [1:0]  DEF_MODE       = 2'b01;
   localparam int          MAX_K          = SYNC_STAGES + TIMEOUT_CYCLES;

   typedef logic [3:0] strap_v;   // {mode[1:0], dbg, clk_byp}

   typedef struct {
      string      name;
      strap_v     pads;
      int         lat;
      logic [5:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [1:0] boot_mode_i = 2'b00;
   logic       debug_en_i = 1'b0;
   logic       clk_byp_en_i = 1'b0;
   logic       debug_lock_i = 1'b0;
   logic       relatch_i = 1'b0;
   logic [1:0] boot_mode_o;
   logic       debug_en_o;
   logic       clk_byp_en_o;
   logic       straps_valid_o;
   logic       straps_err_o;

   int         n_cmp = 0;
   int         n_bad = 0;
   strap_v     seq [MAX_K+1];
   logic [5:0] held_vec;

   always #5 clk = ~clk;

   boot_strap_sampler #(
      .SYNC_STAGES    (SYNC_STAGES),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .boot_mode_i    (boot_mode_i),
      .debug_en_i     (debug_en_i),
      .clk_byp_en_i   (clk_byp_en_i),
      .debug_lock_i   (debug_lock_i),
      .relatch_i      (relatch_i),
      .boot_mode_o    (boot_mode_o),
      .debug_en_o     (debug_en_o),
      .clk_byp_en_o   (clk_byp_en_o),
      .straps_valid_o (straps_valid_o),
      .straps_err_o   (straps_err_o)
   );

   function automatic logic [5:0] obs();
      return {straps_valid_o, straps_err_o, boot_mode_o, debug_en_o, clk_byp_en_o};
   endfunction

   function automatic logic [5:0] mask(input logic [5:0] v, input logic lock);
      logic [5:0] r;
      r    = v;
      r[1] = v[1] & ~lock;
      return r;
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pads(input strap_v v);
      boot_mode_i  = v[3:2];
      debug_en_i   = v[1];
      clk_byp_en_i = v[0];
   endtask

   // Reference: the FILTER sample at edge k (counted from the origin edge)
   // is the pad level sampled SYNC_STAGES edges earlier. Accept once
   // STABLE_CYCLES identical samples in a row are seen; otherwise fall back
   // after TIMEOUT_CYCLES samples.
   task automatic predict(output int lat, output logic [5:0] exp);
      int     run;
      strap_v prev;
      run  = 0;
      prev = '0;
      lat  = MAX_K;
      exp  = {1'b1, 1'b1, DEF_MODE, 2'b00};
      for (int idx = 0; idx < int'(TIMEOUT_CYCLES); idx++) begin
         strap_v smp;
         smp = seq[idx + 1];
         if (idx > 0 && smp == prev) run++;
         else run = 1;
         prev = smp;
         if (run >= int'(STABLE_CYCLES)) begin
            lat = idx + int'(SYNC_STAGES) + 1;
            exp = {1'b1, 1'b0, smp};
            return;
         end
      end
   endtask

   task automatic do_reset(input string name);
      rst_i     = 1'b1;
      relatch_i = 1'b0;
      step();
      step();
      check({name, " reset"}, obs(), {1'b0, 1'b0, DEF_MODE, 1'b0, 1'b0});
      rst_i    = 1'b0;
      held_vec = {1'b0, 1'b0, DEF_MODE, 2'b00};
   endtask

   task automatic do_relatch(input string name);
      relatch_i = 1'b1;
      step();
      relatch_i = 1'b0;
      check({name, " relatch"}, obs(), mask({1'b0, held_vec[4:0]}, debug_lock_i));
   endtask

   // Drives seq[1..] from the origin edge; checks every cycle until lat.
   task automatic run_capture(input string name, input int lat, input logic [5:0] exp,
                              input bit rand_lock);
      for (int k = 1; k <= MAX_K; k++) begin
         set_pads(seq[k]);
         if (rand_lock) debug_lock_i = 1'($urandom_range(0, 1));
         step();
         if (k < lat) begin
            check({name, " wait"}, obs(), mask({1'b0, held_vec[4:0]}, debug_lock_i));
         end else begin
            check({name, " latch"}, obs(), mask(exp, debug_lock_i));
            break;
         end
      end
      held_vec = exp;
   endtask

   task automatic hold_check(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         set_pads(4'($urandom_range(0, 15)));
         step();
         check({name, " hold"}, obs(), mask(held_vec, debug_lock_i));
      end
   endtask

   task automatic fill_const(input strap_v v);
      for (int k = 0; k <= MAX_K; k++) seq[k] = v;
   endtask

   initial begin
      vec_t       tbl [4];
      int         lat;
      logic [5:0] exp;

      tbl[0] = '{name: "T1_m2_dbg",  pads: 4'b1010, lat: 18, exp: 6'b101010};
      tbl[1] = '{name: "static_0",   pads: 4'b0000, lat: 18, exp: 6'b100000};
      tbl[2] = '{name: "static_all", pads: 4'b1111, lat: 18, exp: 6'b101111};
      tbl[3] = '{name: "m1_byp",     pads: 4'b0101, lat: 18, exp: 6'b100101};

      for (int i = 0; i < 4; i++) begin
         fill_const(tbl[i].pads);
         set_pads(tbl[i].pads);
         do_reset(tbl[i].name);
         run_capture(tbl[i].name, tbl[i].lat, tbl[i].exp, 1'b0);
         hold_check(tbl[i].name, 4);
      end

      // T2: mode toggles 1<->3 every 8 cycles, never stable long enough
      for (int k = 0; k <= MAX_K; k++)
         seq[k] = (((k - 1) / 8) % 2 == 1) ? 4'b1100 : 4'b0100;
      do_reset("T2");
      run_capture("T2", 1026, 6'b110100, 1'b0);

      // T3: one-cycle glitch 0->3->0 at filter cycle 10
      fill_const(4'b0000);
      seq[11] = 4'b1100;
      do_reset("T3");
      run_capture("T3", 29, 6'b100000, 1'b0);

      // T4: locked with mode 1, pads move to 3, relatch
      fill_const(4'b0100);
      do_reset("T4");
      run_capture("T4a", 18, 6'b100100, 1'b0);
      hold_check("T4", 5);
      fill_const(4'b1100);
      set_pads(4'b1100);
      do_relatch("T4");
      run_capture("T4b", 18, 6'b101100, 1'b0);

      // T5: debug lock masks debug_en_o combinationally
      fill_const(4'b0010);
      do_reset("T5");
      run_capture("T5", 18, 6'b100010, 1'b0);
      debug_lock_i = 1'b1;
      #1;
      check("T5 lock_on", obs(), 6'b100000);
      debug_lock_i = 1'b0;
      #1;
      check("T5 lock_off", obs(), 6'b100010);

      // T6: reset at filter cycle 5 during a relatch capture
      fill_const(4'b1011);
      do_reset("T6");
      run_capture("T6a", 18, 6'b101011, 1'b0);
      do_relatch("T6");
      for (int k = 1; k <= 7; k++) begin
         set_pads(seq[k]);
         step();
         check("T6 partial", obs(), {1'b0, held_vec[4:0]});
      end
      do_reset("T6 mid");
      run_capture("T6b", 18, 6'b101011, 1'b0);

      // Randomized pad sequences
      for (int t = 0; t < 12; t++) begin
         int     kind;
         int     prefix;
         int     left;
         strap_v base;
         kind = int'($urandom_range(0, 2));
         base = 4'($urandom_range(0, 15));
         if (kind == 0) begin
            prefix = int'($urandom_range(0, 40));
            for (int k = 0; k <= MAX_K; k++)
               seq[k] = (k <= prefix) ? 4'($urandom_range(0, 15)) : base;
         end else if (kind == 1) begin
            left = 0;
            for (int k = 0; k <= MAX_K; k++) begin
               if (left == 0) begin
                  base = base ^ 4'($urandom_range(1, 15));
                  left = int'($urandom_range(1, 15));
               end
               seq[k] = base;
               left--;
            end
         end else begin
            for (int k = 0; k <= MAX_K; k++)
               seq[k] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : base;
         end
         predict(lat, exp);
         if (t % 2 == 1) do_relatch("rand");
         else do_reset("rand");
         run_capture("rand", lat, exp, 1'b1);
         hold_check("rand", 3);
      end
      debug_lock_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
